hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Keeps its own shadow pipeline of destination, source and control bits for the EX, MEM and WB stages.
- From that state it generates PC/IF-ID enables, ID/EX bubble insertion, branch flushes and ALU operand forward selects.
- Two modes: full forwarding with load-use stall, or no forwarding with stall-until-retire. Saturating stall and flush counters support performance analysis.

Parameters:
- RA_W, 5, register address width.
- FWD_EN, 1, 1 = forwarding from EX/MEM and MEM/WB; 0 = no forwarding, interlock on every RAW.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  RA_W  source register 1 (instr[25:21]).
- id_rt  in  RA_W  source register 2 (instr[20:16]).
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_dst  in  RA_W  resolved destination (RegDst already applied).
- id_regwrite  in  1  ID instruction writes the register file.
- id_memread  in  1  ID instruction is a load.
- branch_taken  in  1  branch in MEM stage is taken (Branch & Zero).
- pc_en  out  1  PC load enable.
- ifid_en  out  1  IF/ID buffer load enable.
- ifid_flush  out  1  clear IF/ID to NOP next edge.
- idex_bubble  out  1  load NOP control into ID/EX next edge.
- exmem_flush  out  1  clear EX/MEM control next edge.
- fwd_a  out  2  ALU A select: 00 register file, 01 MEM/WB result, 10 EX/MEM result.
- fwd_b  out  2  ALU B select (before ALUSrc mux), same encoding.
- stall_cnt  out  CNT_W  stall cycles since reset, saturating.
- flush_cnt  out  CNT_W  taken-branch flushes since reset, saturating.

Behaviour:
Shadow state per stage S in {ex, mem, wb}:
- Fields: v, rw, mr, dst, rs, rt, urs, urt.
- A stage is "writing r" when v & rw & dst==r & r!=0.
- Register 0 never matches.

Hazard detection (combinational from inputs and shadows), with id_valid=1 and the relevant use bit set:
- FWD_EN=1: hz = ex.v & ex.mr & ex writing id_rs or id_rt.
- FWD_EN=0: hz = any of ex, mem, wb writing id_rs or id_rt. The register file has no write-through bypass, so WB is included.

Output priority, evaluated every cycle:
1. rst=1: pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, exmem_flush=1, fwd=00.
2. branch_taken=1: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1, exmem_flush=1. Flush overrides hz, and no stall is counted.
3. hz=1: pc_en=0, ifid_en=0, idex_bubble=1; flush outputs 0.
4. Otherwise: pc_en=1, ifid_en=1; all flush and bubble outputs 0.

Shadow update on each rising edge:
- rst: all v=0; counters=0.
- Otherwise wb<=mem always.
- mem <= ex, or invalid if branch_taken.
- ex <= ID inputs with v=id_valid, or invalid if branch_taken or hz.

Forwarding (FWD_EN=1 only; forced to 00 when FWD_EN=0):
- fwd_a=10 if mem writing ex.rs & ex.urs; else 01 if wb writing ex.rs & ex.urs; else 00.
- fwd_b is the same using ex.rt and ex.urt.
- The younger MEM stage wins when both match.
- Selects are valid only when ex.v=1, and are forced to 00 when ex.v=0.

Counters:
- stall_cnt += 1 in each cycle where hz & ~branch_taken & ~rst.
- flush_cnt += 1 in each cycle where branch_taken & ~rst.
- Both hold at 2^CNT_W-1.

Boundaries:
- A load-use stall lasts exactly 1 cycle in FWD_EN=1.
- In FWD_EN=0, the stall lasts up to 3 cycles: until the producer leaves WB.
- A stall on a flushed instruction is discarded by the flush.
- Reset mid-stall or mid-flush clears everything; the first cycle after rst drops has pc_en=1.

Test Plan:
- FWD_EN=1: lw $8 followed by add $9,$8,$2 → one cycle of pc_en=0, idex_bubble=1; next cycle fwd_a=01; stall_cnt=1.
- FWD_EN=1: add $8 ; sub $10,$8,$8 → no stall; fwd_a=10, fwd_b=10. With one unrelated instruction between them → fwd_a=01, fwd_b=01.
- FWD_EN=1: producers writing $0 → fwd=00, no stall.
- FWD_EN=1: add $8 two cycles ahead and add $8 one cycle ahead of a reader → fwd_a=10 (MEM priority).
- FWD_EN=0: add $8 then a reader of $8 → 3 stall cycles, stall_cnt=3, fwd=00 throughout.
- FWD_EN=1: branch_taken asserted in the same cycle as a load-use hz → ifid_flush, idex_bubble and exmem_flush asserted, pc_en=1, flush_cnt=1, stall_cnt unchanged.
- CNT_W=2: force 5 stalls → stall_cnt=3 (saturated).
- Assert rst during a FWD_EN=0 stall → outputs take their reset values. The cycle after rst drops: pc_en=1, counters=0.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
// ---------------
// Hazard detection and operand-forwarding controller for a classic
// 5-stage pipeline (IF, ID, EX, MEM, WB). A small shadow copy of the
// EX, MEM and WB stages (valid, regwrite, memread, destination, sources
// and source-use bits) is kept locally. The PC/IF-ID enables, ID/EX
// bubble, branch flushes and ALU operand selects are all derived from
// that shadow state and the instruction currently sitting in ID.
//
// Parameters
//   RA_W   register address width
//   FWD_EN 1 = forward from EX/MEM and MEM/WB, stall only on load-use
//          0 = no forwarding, stall until the producer has retired
//   CNT_W  width of the saturating performance counters
//
// Ports
//   clk, rst                   clock (rising edge), synchronous active-high reset
//   id_valid                   ID holds a real instruction
//   id_rs, id_rt               ID source registers
//   id_use_rs, id_use_rt       ID instruction actually reads rs / rt
//   id_dst                     ID destination register (after RegDst)
//   id_regwrite, id_memread    ID writes the register file / is a load
//   branch_taken               branch resolved taken in MEM
//   pc_en, ifid_en             PC and IF/ID load enables
//   ifid_flush                 clear IF/ID on next edge
//   idex_bubble                load NOP control into ID/EX on next edge
//   exmem_flush                clear EX/MEM control on next edge
//   fwd_a, fwd_b               ALU operand selects: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   stall_cnt, flush_cnt       saturating stall-cycle and taken-branch counters
module hazard_fwd_unit #(
    parameter int RA_W   = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [RA_W-1:0]  id_dst,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic            v;
        logic            rw;
        logic            mr;
        logic [RA_W-1:0] dst;
        logic [RA_W-1:0] rs;
        logic [RA_W-1:0] rt;
        logic            urs;
        logic            urt;
    } stage_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    stage_t ex_q;
    stage_t mem_q;
    stage_t wb_q;

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;
    logic hz;

    // A stage produces register r only if it is a live register write to a
    // non-zero destination; register 0 is hard-wired and never forwarded.
    function automatic logic writes(input stage_t s, input logic [RA_W-1:0] r);
        return s.v & s.rw & (s.dst == r) & (r != '0);
    endfunction

    // RAW detection against each shadow stage. With forwarding only a load
    // in EX cannot be bypassed in time; without forwarding every in-flight
    // producer must retire first, including WB since the register file has
    // no write-through path.
    always_comb begin
        ex_hit  = (id_use_rs & writes(ex_q,  id_rs)) | (id_use_rt & writes(ex_q,  id_rt));
        mem_hit = (id_use_rs & writes(mem_q, id_rs)) | (id_use_rt & writes(mem_q, id_rt));
        wb_hit  = (id_use_rs & writes(wb_q,  id_rs)) | (id_use_rt & writes(wb_q,  id_rt));
        if (FWD_EN != 0) begin
            hz = id_valid & ex_q.mr & ex_hit;
        end else begin
            hz = id_valid & (ex_hit | mem_hit | wb_hit);
        end
    end

    // Pipeline control with fixed priority: reset, then taken-branch flush
    // (which also discards any stall on the wrong-path instruction), then
    // stall, then normal flow.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (hz) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Operand selects for the instruction in EX. MEM is the younger producer
    // and therefore holds the most recent value when both MEM and WB match.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if ((FWD_EN != 0) && !rst && ex_q.v) begin
            if (ex_q.urs && writes(mem_q, ex_q.rs)) begin
                fwd_a = 2'b10;
            end else if (ex_q.urs && writes(wb_q, ex_q.rs)) begin
                fwd_a = 2'b01;
            end
            if (ex_q.urt && writes(mem_q, ex_q.rt)) begin
                fwd_b = 2'b10;
            end else if (ex_q.urt && writes(wb_q, ex_q.rt)) begin
                fwd_b = 2'b01;
            end
        end
    end

    // Shadow pipeline advance and performance counters. A taken branch kills
    // the instructions entering EX and MEM; a stall turns the ID/EX slot into
    // a bubble while the ID instruction is held upstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= branch_taken ? '0 : ex_q;
            if (branch_taken || hz) begin
                ex_q <= '0;
            end else begin
                ex_q.v   <= id_valid;
                ex_q.rw  <= id_regwrite;
                ex_q.mr  <= id_memread;
                ex_q.dst <= id_dst;
                ex_q.rs  <= id_rs;
                ex_q.rt  <= id_rt;
                ex_q.urs <= id_use_rs;
                ex_q.urt <= id_use_rt;
            end
            if (hz && !branch_taken && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (branch_taken && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit
// ------------------
// Drives three copies of hazard_fwd_unit from one shared stimulus stream:
//   0: FWD_EN=1, CNT_W=16   1: FWD_EN=0, CNT_W=16   2: FWD_EN=1, CNT_W=2
// Each copy has its own reference model: a three-entry array of in-flight
// instructions (EX, MEM, WB) plus integer counters, evaluated straight from
// the pipeline rules. Directed sequences cover the interesting corners, then
// a randomized stream runs against the same models.
module tb_hazard_fwd_unit;

    localparam int N = 3;
    localparam int CFG_FWD [N] = '{1, 0, 1};
    localparam int CFG_MAX [N] = '{65535, 65535, 3};

    typedef struct {
        bit v;
        bit rw;
        bit mr;
        int dst;
        int rs;
        int rt;
        bit urs;
        bit urt;
    } instr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       id_use_rs = 1'b0;
    logic       id_use_rt = 1'b0;
    logic [4:0] id_dst = '0;
    logic       id_regwrite = 1'b0;
    logic       id_memread = 1'b0;
    logic       branch_taken = 1'b0;

    logic        obs_pc_en       [N];
    logic        obs_ifid_en     [N];
    logic        obs_ifid_flush  [N];
    logic        obs_idex_bubble [N];
    logic        obs_exmem_flush [N];
    logic [1:0]  obs_fwd_a       [N];
    logic [1:0]  obs_fwd_b       [N];
    logic [15:0] obs_stall       [2];
    logic [15:0] obs_flush       [2];
    logic [1:0]  sat_stall;
    logic [1:0]  sat_flush;

    instr_t pipe [N][3];
    int     m_stall [N];
    int     m_flush [N];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.RA_W(5), .FWD_EN(1), .CNT_W(16)) u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .branch_taken(branch_taken),
        .pc_en(obs_pc_en[0]), .ifid_en(obs_ifid_en[0]), .ifid_flush(obs_ifid_flush[0]),
        .idex_bubble(obs_idex_bubble[0]), .exmem_flush(obs_exmem_flush[0]),
        .fwd_a(obs_fwd_a[0]), .fwd_b(obs_fwd_b[0]),
        .stall_cnt(obs_stall[0]), .flush_cnt(obs_flush[0])
    );

    hazard_fwd_unit #(.RA_W(5), .FWD_EN(0), .CNT_W(16)) u_nofwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .branch_taken(branch_taken),
        .pc_en(obs_pc_en[1]), .ifid_en(obs_ifid_en[1]), .ifid_flush(obs_ifid_flush[1]),
        .idex_bubble(obs_idex_bubble[1]), .exmem_flush(obs_exmem_flush[1]),
        .fwd_a(obs_fwd_a[1]), .fwd_b(obs_fwd_b[1]),
        .stall_cnt(obs_stall[1]), .flush_cnt(obs_flush[1])
    );

    hazard_fwd_unit #(.RA_W(5), .FWD_EN(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .branch_taken(branch_taken),
        .pc_en(obs_pc_en[2]), .ifid_en(obs_ifid_en[2]), .ifid_flush(obs_ifid_flush[2]),
        .idex_bubble(obs_idex_bubble[2]), .exmem_flush(obs_exmem_flush[2]),
        .fwd_a(obs_fwd_a[2]), .fwd_b(obs_fwd_b[2]),
        .stall_cnt(sat_stall), .flush_cnt(sat_flush)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int get_stall(input int c);
        return (c == 2) ? int'(sat_stall) : int'(obs_stall[c]);
    endfunction

    function automatic int get_flush(input int c);
        return (c == 2) ? int'(sat_flush) : int'(obs_flush[c]);
    endfunction

    function automatic bit produces(input instr_t s, input int r);
        return s.v && s.rw && (s.dst == r) && (r != 0);
    endfunction

    // Must the ID instruction wait? With forwarding only a load in EX is a
    // problem; without it any older in-flight producer is.
    function automatic bit model_hz(input int c);
        if (!id_valid) return 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (CFG_FWD[c] != 0 && (k != 0 || !pipe[c][k].mr)) continue;
            if ((id_use_rs && produces(pipe[c][k], int'(id_rs))) ||
                (id_use_rt && produces(pipe[c][k], int'(id_rt))))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    // Where should the EX instruction take a source from: the nearest older
    // producer wins (MEM before WB).
    function automatic int model_sel(input int c, input bit use_src, input int src);
        if (rst || CFG_FWD[c] == 0 || !pipe[c][0].v || !use_src) return 0;
        if (produces(pipe[c][1], src)) return 2;
        if (produces(pipe[c][2], src)) return 1;
        return 0;
    endfunction

    task automatic compare_all();
        bit hz;
        bit e_pc, e_ifid, e_iflush, e_bub, e_xflush;
        for (int c = 0; c < N; c++) begin
            hz = model_hz(c);
            if (rst) begin
                {e_pc, e_ifid, e_iflush, e_bub, e_xflush} = 5'b00111;
            end else if (branch_taken) begin
                {e_pc, e_ifid, e_iflush, e_bub, e_xflush} = 5'b11111;
            end else if (hz) begin
                {e_pc, e_ifid, e_iflush, e_bub, e_xflush} = 5'b00010;
            end else begin
                {e_pc, e_ifid, e_iflush, e_bub, e_xflush} = 5'b11000;
            end
            checkOutput($sformatf("c%0d pc_en", c), 32'(obs_pc_en[c]), 32'(e_pc));
            checkOutput($sformatf("c%0d ifid_en", c), 32'(obs_ifid_en[c]), 32'(e_ifid));
            checkOutput($sformatf("c%0d ifid_flush", c), 32'(obs_ifid_flush[c]), 32'(e_iflush));
            checkOutput($sformatf("c%0d idex_bubble", c), 32'(obs_idex_bubble[c]), 32'(e_bub));
            checkOutput($sformatf("c%0d exmem_flush", c), 32'(obs_exmem_flush[c]), 32'(e_xflush));
            checkOutput($sformatf("c%0d fwd_a", c), 32'(obs_fwd_a[c]),
                        32'(model_sel(c, pipe[c][0].urs, pipe[c][0].rs)));
            checkOutput($sformatf("c%0d fwd_b", c), 32'(obs_fwd_b[c]),
                        32'(model_sel(c, pipe[c][0].urt, pipe[c][0].rt)));
            checkOutput($sformatf("c%0d stall_cnt", c), 32'(get_stall(c)), 32'(m_stall[c]));
            checkOutput($sformatf("c%0d flush_cnt", c), 32'(get_flush(c)), 32'(m_flush[c]));
        end
    endtask

    // Move every instruction one stage along using the inputs that were
    // present at the clock edge.
    task automatic advance_model();
        bit     hz;
        instr_t fresh;
        instr_t dead;
        dead = '{default: 0};
        fresh.v   = id_valid;
        fresh.rw  = id_regwrite;
        fresh.mr  = id_memread;
        fresh.dst = int'(id_dst);
        fresh.rs  = int'(id_rs);
        fresh.rt  = int'(id_rt);
        fresh.urs = id_use_rs;
        fresh.urt = id_use_rt;
        for (int c = 0; c < N; c++) begin
            hz = model_hz(c);
            if (rst) begin
                for (int k = 0; k < 3; k++) pipe[c][k] = dead;
                m_stall[c] = 0;
                m_flush[c] = 0;
            end else begin
                pipe[c][2] = pipe[c][1];
                pipe[c][1] = branch_taken ? dead : pipe[c][0];
                pipe[c][0] = (branch_taken || hz) ? dead : fresh;
                if (hz && !branch_taken && m_stall[c] < CFG_MAX[c]) m_stall[c]++;
                if (branch_taken && m_flush[c] < CFG_MAX[c]) m_flush[c]++;
            end
        end
    endtask

    // One pipeline cycle: clock edge, new ID contents, then mid-cycle check.
    task automatic applyStimulus(input bit r, input bit bt, input bit v,
                                 input int rs, input int rt, input bit urs, input bit urt,
                                 input int dst, input bit rw, input bit mr);
        @(posedge clk);
        advance_model();
        #1;
        rst          = r;
        branch_taken = bt;
        id_valid     = v;
        id_rs        = 5'(rs);
        id_rt        = 5'(rt);
        id_use_rs    = urs;
        id_use_rt    = urt;
        id_dst       = 5'(dst);
        id_regwrite  = rw;
        id_memread   = mr;
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic producer(input int dst, input bit mr);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, dst, 1, mr);
    endtask

    task automatic reader(input int rs, input int rt);
        applyStimulus(0, 0, 1, rs, rt, 1, 1, 20, 1, 0);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset values
        do_reset();
        checkOutput("reset pc_en", 32'(obs_pc_en[0]), 32'd0);
        checkOutput("reset ifid_flush", 32'(obs_ifid_flush[0]), 32'd1);

        // Load-use: one stall, then forward from MEM/WB
        idle();
        producer(8, 1);
        reader(8, 2);
        checkOutput("lu stall pc_en", 32'(obs_pc_en[0]), 32'd0);
        checkOutput("lu stall bubble", 32'(obs_idex_bubble[0]), 32'd1);
        reader(8, 2);
        checkOutput("lu resume pc_en", 32'(obs_pc_en[0]), 32'd1);
        idle();
        checkOutput("lu fwd_a", 32'(obs_fwd_a[0]), 32'd1);
        checkOutput("lu stall_cnt", 32'(obs_stall[0]), 32'd1);

        // Back-to-back ALU dependency forwards from EX/MEM
        do_reset();
        producer(8, 0);
        reader(8, 8);
        checkOutput("alu no stall", 32'(obs_pc_en[0]), 32'd1);
        idle();
        checkOutput("alu fwd_a", 32'(obs_fwd_a[0]), 32'd2);
        checkOutput("alu fwd_b", 32'(obs_fwd_b[0]), 32'd2);

        // One unrelated instruction in between forwards from MEM/WB
        do_reset();
        producer(8, 0);
        producer(5, 0);
        reader(8, 8);
        idle();
        checkOutput("gap fwd_a", 32'(obs_fwd_a[0]), 32'd1);
        checkOutput("gap fwd_b", 32'(obs_fwd_b[0]), 32'd1);

        // Writes to $0 never forward or stall
        do_reset();
        producer(0, 1);
        reader(0, 0);
        checkOutput("r0 no stall", 32'(obs_pc_en[0]), 32'd1);
        idle();
        checkOutput("r0 fwd_a", 32'(obs_fwd_a[0]), 32'd0);

        // Two producers of $8: MEM (younger) wins over WB
        do_reset();
        producer(8, 0);
        producer(8, 0);
        reader(8, 3);
        idle();
        checkOutput("prio fwd_a", 32'(obs_fwd_a[0]), 32'd2);

        // No forwarding: stall until producer leaves WB
        do_reset();
        producer(8, 0);
        for (int i = 0; i < 4; i++) begin
            reader(8, 8);
            checkOutput($sformatf("nofwd pc_en %0d", i), 32'(obs_pc_en[1]), (i < 3) ? 32'd0 : 32'd1);
            checkOutput($sformatf("nofwd fwd_a %0d", i), 32'(obs_fwd_a[1]), 32'd0);
        end
        checkOutput("nofwd stall_cnt", 32'(obs_stall[1]), 32'd3);

        // Taken branch in the same cycle as a load-use hazard
        do_reset();
        producer(8, 1);
        applyStimulus(0, 1, 1, 8, 2, 1, 1, 9, 1, 0);
        checkOutput("br pc_en", 32'(obs_pc_en[0]), 32'd1);
        checkOutput("br ifid_flush", 32'(obs_ifid_flush[0]), 32'd1);
        checkOutput("br idex_bubble", 32'(obs_idex_bubble[0]), 32'd1);
        checkOutput("br exmem_flush", 32'(obs_exmem_flush[0]), 32'd1);
        idle();
        checkOutput("br flush_cnt", 32'(obs_flush[0]), 32'd1);
        checkOutput("br stall_cnt", 32'(obs_stall[0]), 32'd0);

        // Five load-use stalls saturate a 2-bit counter at 3
        do_reset();
        for (int i = 0; i < 5; i++) begin
            producer(8, 1);
            reader(8, 1);
            reader(8, 1);
        end
        idle();
        checkOutput("sat stall_cnt", 32'(sat_stall), 32'd3);
        checkOutput("wide stall_cnt", 32'(obs_stall[0]), 32'd5);

        // Reset in the middle of a no-forwarding stall
        do_reset();
        producer(8, 0);
        reader(8, 8);
        reader(8, 8);
        applyStimulus(1, 0, 1, 8, 8, 1, 1, 20, 1, 0);
        checkOutput("midrst pc_en", 32'(obs_pc_en[1]), 32'd0);
        checkOutput("midrst exmem_flush", 32'(obs_exmem_flush[1]), 32'd1);
        reader(8, 8);
        checkOutput("postrst pc_en", 32'(obs_pc_en[1]), 32'd1);
        checkOutput("postrst stall_cnt", 32'(obs_stall[1]), 32'd0);

        // Randomized stream over a small register range to provoke hits
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(39) == 0, $urandom_range(7) == 0,
                          $urandom_range(3) != 0,
                          int'($urandom_range(3)), int'($urandom_range(3)),
                          $urandom_range(1) == 1, $urandom_range(1) == 1,
                          int'($urandom_range(3)), $urandom_range(3) != 0,
                          $urandom_range(2) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
